// File: rtl/ysyx_23060077_axi_rr_sched.sv
// Round-robin scheduler sharing the single AXI bridge request port between IFU read, LSU read and LSU write.
// One transaction is in flight at a time; a beat counter checks each burst against the len latched at grant.
module ysyx_23060077_axi_rr_sched #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              aclk,
    input  logic              areset_n,

    input  logic              ifu_r_valid_i,
    input  logic [ADDR_W-1:0] ifu_r_addr_i,
    input  logic [7:0]        ifu_r_len_i,
    output logic              ifu_r_ready_o,
    output logic [DATA_W-1:0] ifu_r_data_o,
    output logic              ifu_r_last_o,

    input  logic              lsu_r_valid_i,
    input  logic [ADDR_W-1:0] lsu_r_addr_i,
    input  logic [2:0]        lsu_r_size_i,
    input  logic [7:0]        lsu_r_len_i,
    output logic              lsu_r_ready_o,
    output logic [DATA_W-1:0] lsu_r_data_o,
    output logic              lsu_r_last_o,

    input  logic              lsu_w_valid_i,
    input  logic [ADDR_W-1:0] lsu_w_addr_i,
    input  logic [DATA_W-1:0] lsu_w_data_i,
    input  logic [2:0]        lsu_w_size_i,
    input  logic [7:0]        lsu_w_len_i,
    output logic              lsu_w_ready_o,
    output logic              lsu_w_last_o,

    output logic              cpu_r_valid_o,
    output logic [ADDR_W-1:0] cpu_r_addr_o,
    output logic [2:0]        cpu_r_size_o,
    output logic [7:0]        cpu_r_len_o,
    input  logic              cpu_r_ready_i,
    input  logic [DATA_W-1:0] cpu_r_data_i,
    input  logic              cpu_r_last_i,

    output logic              cpu_w_valid_o,
    output logic [ADDR_W-1:0] cpu_w_addr_o,
    output logic [DATA_W-1:0] cpu_w_data_o,
    output logic [2:0]        cpu_w_size_o,
    output logic [7:0]        cpu_w_len_o,
    input  logic              cpu_w_ready_i,
    input  logic              cpu_w_last_i,

    output logic [2:0]        grant_o,
    output logic              busy_o,
    output logic              err_o
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    localparam logic [1:0] OWN_IFU   = 2'd0;
    localparam logic [1:0] OWN_LSU_R = 2'd1;

    state_t     state, state_nx;
    logic [2:0] grant, grant_nx;
    logic [1:0] last_owner, last_owner_nx;
    logic [1:0] prev_owner, prev_owner_nx;
    logic [7:0] beat_cnt, beat_cnt_nx;
    logic [7:0] len_q, len_nx;
    logic [2:0] size_q, size_nx;
    logic       err, err_nx;

    logic [2:0] req;
    logic       owner_rd;
    logic       owner_valid;
    logic       owner_beat;
    logic       owner_last;
    logic       last_ok;
    logic [8:0] len_plus1;
    logic [1:0] pick;
    logic [1:0] cand;
    logic       pick_found;

    assign req         = {lsu_w_valid_i, lsu_r_valid_i, ifu_r_valid_i};
    assign owner_rd    = grant[0] | grant[1];
    assign owner_valid = |(grant & req);
    assign owner_beat  = owner_rd ? cpu_r_ready_i : (grant[2] & cpu_w_ready_i);
    assign owner_last  = owner_rd ? (cpu_r_ready_i & cpu_r_last_i)
                                  : (grant[2] & cpu_w_ready_i & cpu_w_last_i);
    assign len_plus1   = {1'b0, len_q} + 9'd1;

    // A write may finish with last on its final data beat, or with a separate
    // response after all len+1 data beats have been accepted.
    assign last_ok = owner_rd ? (beat_cnt == len_q)
                              : ((beat_cnt == len_q) || ({1'b0, beat_cnt} == len_plus1));

    // Rotating priority: first requester after last_owner, wrapping mod 3.
    always_comb begin
        pick_found = 1'b0;
        pick       = last_owner;
        cand       = '0;
        for (int unsigned k = 1; k <= 3; k++) begin
            cand = 2'((32'(last_owner) + k) % 32'd3);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick       = cand;
            end
        end
    end

    always_comb begin
        state_nx      = state;
        grant_nx      = grant;
        last_owner_nx = last_owner;
        prev_owner_nx = prev_owner;
        beat_cnt_nx   = beat_cnt;
        len_nx        = len_q;
        size_nx       = size_q;
        err_nx        = err;

        if (state == S_IDLE) begin
            if (cpu_r_ready_i || cpu_w_ready_i) begin
                err_nx = 1'b1;
            end
            if (pick_found) begin
                state_nx      = S_BUSY;
                grant_nx      = 3'b001 << pick;
                prev_owner_nx = last_owner;
                last_owner_nx = pick;
                beat_cnt_nx   = '0;
                case (pick)
                    OWN_IFU: begin
                        len_nx  = ifu_r_len_i;
                        size_nx = 3'b010;
                    end
                    OWN_LSU_R: begin
                        len_nx  = lsu_r_len_i;
                        size_nx = lsu_r_size_i;
                    end
                    default: begin
                        len_nx  = lsu_w_len_i;
                        size_nx = lsu_w_size_i;
                    end
                endcase
            end
        end else begin
            if (owner_beat) begin
                beat_cnt_nx = beat_cnt + 8'd1;
                if (owner_last) begin
                    if (!last_ok) begin
                        err_nx = 1'b1;
                    end
                    state_nx = S_IDLE;
                    grant_nx = '0;
                end else if (beat_cnt > len_q) begin
                    err_nx = 1'b1;
                end
            end else if (!owner_valid && beat_cnt == '0) begin
                // Abort before any beat: the aborted turn is handed back.
                state_nx      = S_IDLE;
                grant_nx      = '0;
                last_owner_nx = prev_owner;
            end
            if (!owner_valid && beat_cnt != '0 && !owner_last) begin
                err_nx = 1'b1;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset_n) begin
            state      <= S_IDLE;
            grant      <= '0;
            last_owner <= OWN_IFU;
            prev_owner <= OWN_IFU;
            beat_cnt   <= '0;
            len_q      <= '0;
            size_q     <= '0;
            err        <= 1'b0;
        end else begin
            state      <= state_nx;
            grant      <= grant_nx;
            last_owner <= last_owner_nx;
            prev_owner <= prev_owner_nx;
            beat_cnt   <= beat_cnt_nx;
            len_q      <= len_nx;
            size_q     <= size_nx;
            err        <= err_nx;
        end
    end

    assign cpu_r_valid_o = (grant[0] & ifu_r_valid_i) | (grant[1] & lsu_r_valid_i);
    assign cpu_r_addr_o  = grant[0] ? ifu_r_addr_i : (grant[1] ? lsu_r_addr_i : '0);
    assign cpu_r_size_o  = owner_rd ? size_q : '0;
    assign cpu_r_len_o   = owner_rd ? len_q : '0;

    assign cpu_w_valid_o = grant[2] & lsu_w_valid_i;
    assign cpu_w_addr_o  = grant[2] ? lsu_w_addr_i : '0;
    assign cpu_w_data_o  = grant[2] ? lsu_w_data_i : '0;
    assign cpu_w_size_o  = grant[2] ? size_q : '0;
    assign cpu_w_len_o   = grant[2] ? len_q : '0;

    assign ifu_r_ready_o = grant[0] & cpu_r_ready_i;
    assign ifu_r_data_o  = grant[0] ? cpu_r_data_i : '0;
    assign ifu_r_last_o  = grant[0] & cpu_r_ready_i & cpu_r_last_i;

    assign lsu_r_ready_o = grant[1] & cpu_r_ready_i;
    assign lsu_r_data_o  = grant[1] ? cpu_r_data_i : '0;
    assign lsu_r_last_o  = grant[1] & cpu_r_ready_i & cpu_r_last_i;

    assign lsu_w_ready_o = grant[2] & cpu_w_ready_i;
    assign lsu_w_last_o  = grant[2] & cpu_w_ready_i & cpu_w_last_i;

    assign grant_o = grant;
    assign busy_o  = (state == S_BUSY);
    assign err_o   = err;

endmodule

// File: doc/ysyx_23060077_axi_rr_sched.md
# ysyx_23060077_axi_rr_sched

Round-robin transaction scheduler between the CPU's three memory requesters (IFU/Icache refill read, LSU read, LSU write) and the single `cpu_*` request port of the AXI bridge. Exactly one transaction is outstanding at a time, reads and writes included. The grant is held from issue until the bridge signals completion. A beat counter checks each burst against its declared length and reports violations through a sticky error flag.

## Interface
- `ADDR_W`, 32, request address width
- `DATA_W`, 32, data width
- `aclk`  in  1  clock
- `areset_n`  in  1  reset; synchronous, active-high (asserted = 1, sampled on `aclk` rising edge)
- `ifu_r_valid_i` in 1; `ifu_r_addr_i` in ADDR_W; `ifu_r_len_i` in 8: IFU read request. Size is fixed at 3'b010.
- `ifu_r_ready_o` out 1; `ifu_r_data_o` out DATA_W; `ifu_r_last_o` out 1: IFU beat strobe, data and final-beat flag
- `lsu_r_valid_i` in 1; `lsu_r_addr_i` in ADDR_W; `lsu_r_size_i` in 3; `lsu_r_len_i` in 8: LSU read request
- `lsu_r_ready_o` out 1; `lsu_r_data_o` out DATA_W; `lsu_r_last_o` out 1: LSU read response
- `lsu_w_valid_i` in 1; `lsu_w_addr_i` in ADDR_W; `lsu_w_data_i` in DATA_W; `lsu_w_size_i` in 3; `lsu_w_len_i` in 8: LSU write request
- `lsu_w_ready_o` out 1; `lsu_w_last_o` out 1: write beat accepted / write complete
- `cpu_r_valid_o` out 1; `cpu_r_addr_o` out ADDR_W; `cpu_r_size_o` out 3; `cpu_r_len_o` out 8: read request to bridge
- `cpu_r_ready_i` in 1; `cpu_r_data_i` in DATA_W; `cpu_r_last_i` in 1: read beat from bridge
- `cpu_w_valid_o` out 1; `cpu_w_addr_o` out ADDR_W; `cpu_w_data_o` out DATA_W; `cpu_w_size_o` out 3; `cpu_w_len_o` out 8: write request to bridge
- `cpu_w_ready_i` in 1; `cpu_w_last_i` in 1: write beat accepted; `cpu_w_ready_i & cpu_w_last_i` = write response received
- `grant_o` out 3: one-hot current owner. Bit 0 = IFU, bit 1 = LSU read, bit 2 = LSU write.
- `busy_o` out 1: a transaction is owned
- `err_o` out 1: sticky protocol error

## Operation
- **States.** IDLE and BUSY, plus a registered one-hot `grant` and a registered `last_owner` pointer.
- **IDLE.** Evaluates the three valids in rotating priority, starting with the requester after `last_owner`.
  - Reset value of `last_owner` is IFU, so the order after reset is LSU_R > LSU_W > IFU.
  - On a winner, registers `grant` and `last_owner`, clears the beat counter, and moves to BUSY.
  - With no valid, stays in IDLE.
- **BUSY.** Routes only the owner's request onto the matching `cpu_r_*` or `cpu_w_*` group.
  - Non-owner request fields on the bridge side are driven to 0.
  - Non-owners see ready, last and data = 0.
- **Beat counter (8 bits).** Increments on each owner beat: `cpu_r_ready_i` for reads, `cpu_w_ready_i` for writes.
- **Read completion.** `cpu_r_ready_i & cpu_r_last_i`.
- **Write completion.** `cpu_w_ready_i & cpu_w_last_i`.
- **On completion.** State goes to IDLE and `grant` clears to 0.
- **`err_o` set conditions.** Any of the following sets `err_o`, which is cleared only by reset:
  - last arrives with beat count ≠ owner's len;
  - a beat arrives beyond len;
  - owner valid drops after its first beat.
- **Abort.** If the owner's valid drops in BUSY before any beat, the grant is released: go to IDLE with `last_owner` unchanged and no error.
- **Latched request fields.** Len and size are latched at grant and used for the beat check. Address and data pass through live from the owner.
- **Unsolicited responses.** Bridge beats in IDLE are ignored, and `err_o` is set.

## Timing
- **Reset values.** All `*_valid_o`, `*_ready_o` and `*_last_o` outputs are 0, as are all data, address, size and len outputs. `grant_o = 0`, `busy_o = 0`, `err_o = 0`, state IDLE, `last_owner = IFU`, beat counter 0.
- **Reset mid-transaction.** Drops all outputs to reset values on the next edge. A bridge beat in that cycle is discarded.
- **Grant latency.** A request valid in IDLE at cycle t gives `grant_o`/`busy_o` = 1 and `cpu_*_valid_o` = 1 at t+1.
- **Response path.** Combinational from the bridge to the owner in the same cycle: ready, last, data.
- **Back-to-back.** Completion at cycle t gives IDLE at t+1 and the next grant at t+2. There is a one-cycle bubble between transactions.
- **Simultaneous requests.** The rotation decides, so one requester wins per arbitration. A requester that keeps requesting waits at most two other transactions.
- **Valid in the completion cycle.** A requester whose valid is still high in the completion cycle is treated as a new request in the next IDLE cycle.

## Test plan
- **Reset and first arbitration.** Hold `areset_n` = 1 for 2 cycles, then raise all three valids together → grants in order LSU_R (010), LSU_W (100), IFU (001). Each transaction has len = 0 and a single-beat completion. Each `busy_o` = 1 window is separated by a one-cycle gap.
- **IFU burst.**
  - Stimulus: IFU len = 3; bridge returns 4 beats, data 0x11..0x44, last on the 4th beat.
  - Required response: `ifu_r_data_o` follows the beats and `ifu_r_last_o` pulses once.
  - `cpu_r_size_o = 3'b010`; `err_o` stays 0; `lsu_r_ready_o` stays 0 throughout.
- **Write.**
  - Stimulus: LSU write to 0x8000_0010, data 0xDEADBEEF, len 0; bridge gives `cpu_w_ready_i` beat, then `cpu_w_ready_i & cpu_w_last_i` 3 cycles later.
  - Required response: `cpu_w_valid_o` is held until completion, then IDLE.
- **Length violation.** LSU read len = 1 with last on the 1st beat → `err_o` = 1 the next cycle and remains 1 until reset; the grant still releases.
- **Abort and mid-burst reset.**
  - IFU valid pulses for 1 cycle with no beat → grant released, no error, `last_owner` unchanged.
  - Reset asserted during the 2nd beat of a len = 3 read → all outputs 0 the next cycle.
